// File: rtl/cv32e41p_rf_wb_arbiter.sv
// rtl/cv32e41p_rf_wb_arbiter.sv - Arbitrates LSU/ALU/MUL writebacks onto two registered register-file write ports
module cv32e41p_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  mul_valid_i,
    input  logic [ADDR_WIDTH-1:0] mul_addr_i,
    input  logic [DATA_WIDTH-1:0] mul_data_i,
    output logic                  lsu_ready_o,
    output logic                  alu_ready_o,
    output logic                  mul_ready_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    output logic                  busy_o
);

    // Without a separate FP bank (or with Zfinx) bit 5 is folded into the integer bank.
    function automatic logic [ADDR_WIDTH-1:0] eff_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = a;
        if (FPU == 0 || ZFINX == 1) begin
            r[5] = 1'b0;
        end
        return r;
    endfunction

    logic                  r_rr;
    logic                  r_we_a;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_waddr_a;
    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_a;
    logic [DATA_WIDTH-1:0] r_wdata_b;

    logic [ADDR_WIDTH-1:0] w_lsu_addr;
    logic [ADDR_WIDTH-1:0] w_alu_addr;
    logic [ADDR_WIDTH-1:0] w_mul_addr;
    logic                  w_arb_en;
    logic                  w_alu_ne_lsu;
    logic                  w_mul_ne_lsu;
    logic                  w_alu_eq_mul;
    logic                  w_lsu_rdy;
    logic                  w_alu_rdy;
    logic                  w_mul_rdy;
    logic                  w_lsu_go;
    logic                  w_alu_go;
    logic                  w_mul_go;
    logic                  w_a_go;
    logic                  w_b_go;
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [ADDR_WIDTH-1:0] w_b_addr;
    logic [DATA_WIDTH-1:0] w_a_data;
    logic [DATA_WIDTH-1:0] w_b_data;
    logic                  w_contend;

    assign w_lsu_addr   = eff_addr(lsu_addr_i);
    assign w_alu_addr   = eff_addr(alu_addr_i);
    assign w_mul_addr   = eff_addr(mul_addr_i);
    assign w_arb_en     = !rst && !flush_i;
    assign w_alu_ne_lsu = (w_alu_addr != w_lsu_addr);
    assign w_mul_ne_lsu = (w_mul_addr != w_lsu_addr);
    assign w_alu_eq_mul = (w_alu_addr == w_mul_addr);

    // Each ready is what that requester would get if it were valid, so it never looks at its own valid.
    always_comb begin
        w_lsu_rdy = 1'b0;
        w_alu_rdy = 1'b0;
        w_mul_rdy = 1'b0;
        if (w_arb_en) begin
            w_lsu_rdy = 1'b1;
            if (lsu_valid_i) begin
                w_alu_rdy = w_alu_ne_lsu && (!r_rr || !(mul_valid_i && w_mul_ne_lsu));
                w_mul_rdy = w_mul_ne_lsu && ( r_rr || !(alu_valid_i && w_alu_ne_lsu));
            end else begin
                w_alu_rdy = !(mul_valid_i && w_alu_eq_mul &&  r_rr);
                w_mul_rdy = !(alu_valid_i && w_alu_eq_mul && !r_rr);
            end
        end
    end

    assign w_lsu_go = lsu_valid_i && w_lsu_rdy;
    assign w_alu_go = alu_valid_i && w_alu_rdy;
    assign w_mul_go = mul_valid_i && w_mul_rdy;

    // LSU owns port B when it writes; the single ALU/MUL winner then moves to port A.
    assign w_a_go   = w_alu_go || (w_mul_go && lsu_valid_i);
    assign w_a_addr = w_alu_go ? w_alu_addr : w_mul_addr;
    assign w_a_data = w_alu_go ? alu_data_i : mul_data_i;
    assign w_b_go   = w_lsu_go || (w_mul_go && !lsu_valid_i);
    assign w_b_addr = w_lsu_go ? w_lsu_addr : w_mul_addr;
    assign w_b_data = w_lsu_go ? lsu_data_i : mul_data_i;

    assign w_contend = w_arb_en && alu_valid_i && mul_valid_i && (w_alu_go ^ w_mul_go);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr      <= 1'b0;
            r_we_a    <= 1'b0;
            r_we_b    <= 1'b0;
            r_waddr_a <= '0;
            r_waddr_b <= '0;
            r_wdata_a <= '0;
            r_wdata_b <= '0;
        end else begin
            r_we_a <= w_a_go && (w_a_addr != '0);
            r_we_b <= w_b_go && (w_b_addr != '0);
            if (w_a_go) begin
                r_waddr_a <= w_a_addr;
                r_wdata_a <= w_a_data;
            end
            if (w_b_go) begin
                r_waddr_b <= w_b_addr;
                r_wdata_b <= w_b_data;
            end
            if (w_contend) begin
                r_rr <= w_alu_go;
            end
        end
    end

    assign lsu_ready_o = w_lsu_rdy;
    assign alu_ready_o = w_alu_rdy;
    assign mul_ready_o = w_mul_rdy;
    assign waddr_a_o   = r_waddr_a;
    assign wdata_a_o   = r_wdata_a;
    assign we_a_o      = r_we_a;
    assign waddr_b_o   = r_waddr_b;
    assign wdata_b_o   = r_wdata_b;
    assign we_b_o      = r_we_b;
    assign busy_o      = r_we_a || r_we_b;

endmodule

// File: tb/tb_cv32e41p_rf_wb_arbiter.sv
// tb/tb_cv32e41p_rf_wb_arbiter.sv - Self-checking bench for cv32e41p_rf_wb_arbiter
module tb_cv32e41p_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        lv, av, mv;
    logic [5:0]  la, aa, ma;
    logic [31:0] ld, ad, md;

    logic [1:0]       lsu_rdy, alu_rdy, mul_rdy, we_a, we_b, busy;
    logic [1:0][5:0]  waddr_a, waddr_b;
    logic [1:0][31:0] wdata_a, wdata_b;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state per instance: 0 = FP bank visible, 1 = Zfinx folding
    logic        m_rr   [2];
    logic        m_we_a [2];
    logic        m_we_b [2];
    logic [5:0]  m_wa_a [2];
    logic [5:0]  m_wa_b [2];
    logic [31:0] m_wd_a [2];
    logic [31:0] m_wd_b [2];

    always #5 clk = ~clk;

    cv32e41p_rf_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(0)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .lsu_valid_i(lv), .lsu_addr_i(la), .lsu_data_i(ld),
        .alu_valid_i(av), .alu_addr_i(aa), .alu_data_i(ad),
        .mul_valid_i(mv), .mul_addr_i(ma), .mul_data_i(md),
        .lsu_ready_o(lsu_rdy[0]), .alu_ready_o(alu_rdy[0]), .mul_ready_o(mul_rdy[0]),
        .waddr_a_o(waddr_a[0]), .wdata_a_o(wdata_a[0]), .we_a_o(we_a[0]),
        .waddr_b_o(waddr_b[0]), .wdata_b_o(wdata_b[0]), .we_b_o(we_b[0]),
        .busy_o(busy[0])
    );

    cv32e41p_rf_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(1)) u_dut_z (
        .clk(clk), .rst(rst), .flush_i(flush),
        .lsu_valid_i(lv), .lsu_addr_i(la), .lsu_data_i(ld),
        .alu_valid_i(av), .alu_addr_i(aa), .alu_data_i(ad),
        .mul_valid_i(mv), .mul_addr_i(ma), .mul_data_i(md),
        .lsu_ready_o(lsu_rdy[1]), .alu_ready_o(alu_rdy[1]), .mul_ready_o(mul_rdy[1]),
        .waddr_a_o(waddr_a[1]), .wdata_a_o(wdata_a[1]), .we_a_o(we_a[1]),
        .waddr_b_o(waddr_b[1]), .wdata_b_o(wdata_b[1]), .we_b_o(we_b[1]),
        .busy_o(busy[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] eff(input int c, input logic [5:0] a);
        return (c == 1) ? {1'b0, a[4:0]} : a;
    endfunction

    // Returns {lsu, alu, mul} grants for a set of requests, straight from the arbitration rules.
    function automatic logic [2:0] grants(input int c, input logic rs, input logic fl,
                                          input logic l_v, input logic [5:0] l_a,
                                          input logic a_v, input logic [5:0] a_a,
                                          input logic m_v, input logic [5:0] m_a,
                                          input logic rr);
        logic [2:0] g;
        logic [5:0] el, ea, em;
        el = eff(c, l_a);
        ea = eff(c, a_a);
        em = eff(c, m_a);
        g  = 3'b000;
        if (!rs && !fl) begin
            if (l_v) begin
                g = 3'b100;
                if (!rr) begin
                    if (a_v && ea != el)      g = 3'b110;
                    else if (m_v && em != el) g = 3'b101;
                end else begin
                    if (m_v && em != el)      g = 3'b101;
                    else if (a_v && ea != el) g = 3'b110;
                end
            end else if (a_v && m_v) begin
                if (ea != em) g = 3'b011;
                else          g = rr ? 3'b001 : 3'b010;
            end else begin
                g = {1'b0, a_v, m_v};
            end
        end
        return g;
    endfunction

    task automatic step(input logic rs, input logic fl,
                        input logic l_v, input logic [5:0] l_a, input logic [31:0] l_d,
                        input logic a_v, input logic [5:0] a_a, input logic [31:0] a_d,
                        input logic m_v, input logic [5:0] m_a, input logic [31:0] m_d);
        logic [2:0] g [2];
        logic [2:0] t;
        @(negedge clk);
        rst = rs; flush = fl;
        lv = l_v; la = l_a; ld = l_d;
        av = a_v; aa = a_a; ad = a_d;
        mv = m_v; ma = m_a; md = m_d;
        #1;
        for (int c = 0; c < 2; c++) begin
            g[c] = grants(c, rs, fl, l_v, l_a, a_v, a_a, m_v, m_a, m_rr[c]);
            t = grants(c, rs, fl, 1'b1, l_a, a_v, a_a, m_v, m_a, m_rr[c]);
            check_eq($sformatf("c%0d lsu_ready", c), lsu_rdy[c], t[2]);
            t = grants(c, rs, fl, l_v, l_a, 1'b1, a_a, m_v, m_a, m_rr[c]);
            check_eq($sformatf("c%0d alu_ready", c), alu_rdy[c], t[1]);
            t = grants(c, rs, fl, l_v, l_a, a_v, a_a, 1'b1, m_a, m_rr[c]);
            check_eq($sformatf("c%0d mul_ready", c), mul_rdy[c], t[0]);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (rs) begin
                m_rr[c] = 0; m_we_a[c] = 0; m_we_b[c] = 0;
                m_wa_a[c] = 0; m_wa_b[c] = 0; m_wd_a[c] = 0; m_wd_b[c] = 0;
            end else begin
                m_we_a[c] = 0;
                m_we_b[c] = 0;
                if (g[c][2]) begin
                    m_wa_b[c] = eff(c, l_a); m_wd_b[c] = l_d; m_we_b[c] = (m_wa_b[c] != 0);
                    if (g[c][1]) begin
                        m_wa_a[c] = eff(c, a_a); m_wd_a[c] = a_d; m_we_a[c] = (m_wa_a[c] != 0);
                    end else if (g[c][0]) begin
                        m_wa_a[c] = eff(c, m_a); m_wd_a[c] = m_d; m_we_a[c] = (m_wa_a[c] != 0);
                    end
                end else begin
                    if (g[c][1]) begin
                        m_wa_a[c] = eff(c, a_a); m_wd_a[c] = a_d; m_we_a[c] = (m_wa_a[c] != 0);
                    end
                    if (g[c][0]) begin
                        m_wa_b[c] = eff(c, m_a); m_wd_b[c] = m_d; m_we_b[c] = (m_wa_b[c] != 0);
                    end
                end
                if (!fl && a_v && m_v && (g[c][1] ^ g[c][0])) m_rr[c] = g[c][1];
            end
            check_eq($sformatf("c%0d we_a", c), we_a[c], m_we_a[c]);
            check_eq($sformatf("c%0d we_b", c), we_b[c], m_we_b[c]);
            check_eq($sformatf("c%0d waddr_a", c), waddr_a[c], m_wa_a[c]);
            check_eq($sformatf("c%0d waddr_b", c), waddr_b[c], m_wa_b[c]);
            check_eq($sformatf("c%0d wdata_a", c), wdata_a[c], m_wd_a[c]);
            check_eq($sformatf("c%0d wdata_b", c), wdata_b[c], m_wd_b[c]);
            check_eq($sformatf("c%0d busy", c), busy[c], m_we_a[c] | m_we_b[c]);
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_rr[c] = 0; m_we_a[c] = 0; m_we_b[c] = 0;
            m_wa_a[c] = 0; m_wa_b[c] = 0; m_wd_a[c] = 0; m_wd_b[c] = 0;
        end
        rst = 1; flush = 0; lv = 0; av = 0; mv = 0;
        la = 0; aa = 0; ma = 0; ld = 0; ad = 0; md = 0;

        step(1, 0, 1, 6'd5, 32'h1, 1, 6'd6, 32'h2, 1, 6'd7, 32'h3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // three-way request, ALU preferred
        step(0, 0, 1, 6'd5, 32'hAAAA, 1, 6'd6, 32'h1111, 1, 6'd7, 32'h2222);
        check_eq("d32 waddr_b", waddr_b[0], 6'd5);
        check_eq("d32 wdata_a", wdata_a[0], 32'h1111);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd7, 32'h2222);
        check_eq("d32 mul late", we_b[0], 1'b1);

        // same-address ALU/MUL contention
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 6'd9, 32'h99, 1, 6'd9, 32'h77);
        check_eq("d33 alu only", {we_a[0], we_b[0]}, 2'b10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd9, 32'h77);
        check_eq("d33 mul on b", waddr_b[0], 6'd9);

        // x0 write dropped
        step(0, 0, 0, 0, 0, 1, 6'd0, 32'hDEAD, 0, 0, 0);
        check_eq("d34 busy", busy[0], 1'b0);

        // FP bank address with and without Zfinx folding
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h23, 32'h5);
        check_eq("d35 fp", waddr_b[0], 6'h23);
        check_eq("d35 zfinx", waddr_b[1], 6'h03);

        // flush
        step(0, 1, 1, 6'd1, 32'h1, 1, 6'd2, 32'h2, 1, 6'd3, 32'h3);
        check_eq("d36 we", {we_a[0], we_b[0]}, 2'b00);

        // reset right after an LSU transfer
        step(0, 0, 1, 6'd5, 32'h55, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 6'd5, 32'h55, 0, 0, 0, 0, 0, 0);
        check_eq("d37 rst we_b", we_b[0], 1'b0);
        step(0, 0, 1, 6'd1, 32'h11, 0, 0, 0, 0, 0, 0);
        check_eq("d37 after rst", we_b[0], 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, 6'(($urandom_range(0, 1) << 5) | $urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 3) != 0, 6'(($urandom_range(0, 1) << 5) | $urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 3) != 0, 6'(($urandom_range(0, 1) << 5) | $urandom_range(0, 3)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/cv32e41p_rf_wb_arbiter.md
CV32E41P_RF_WB_ARBITER -- requirements
Module: cv32e41p_rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, register-file write address width; bit 5 selects the FP bank.
REQ-002 Parameter DATA_WIDTH, default 32, write data width.
REQ-003 Parameter FPU, default 0; 1 enables FP-bank addresses (addr[5]).
REQ-004 Parameter ZFINX, default 0; 1 forces FP writes into the integer bank.
REQ-005 clk  input  1  clock; one clock, all state on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush_i  input  1  suppresses all grants in the current cycle.
REQ-008 lsu_valid_i / alu_valid_i / mul_valid_i  input  1 each  write request valid.
REQ-009 lsu_addr_i / alu_addr_i / mul_addr_i  input  ADDR_WIDTH each  destination register.
REQ-010 lsu_data_i / alu_data_i / mul_data_i  input  DATA_WIDTH each  write data.
REQ-011 lsu_ready_o / alu_ready_o / mul_ready_o  output  1 each  grant; a transfer occurs when valid and ready are both high.
REQ-012 waddr_a_o, wdata_a_o, we_a_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port A.
REQ-013 waddr_b_o, wdata_b_o, we_b_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port B; port B wins same-address writes in the register file.
REQ-014 busy_o  output  1  high when we_a_o or we_b_o is high.

Function
REQ-015 Effective address: addr[5] forced to 0 when FPU=0 or ZFINX=1; otherwise passed through unchanged.
REQ-016 ready outputs are combinational from the current-cycle valid, address, flush and RR pointer; ready never depends on its own valid.
REQ-017 Port outputs are registered: a transfer in cycle N drives the corresponding port in cycle N+1; latency is exactly 1.
REQ-018 The LSU has fixed top priority: when LSU valid and no flush, lsu_ready_o=1 and the LSU transfer drives port B.
REQ-019 When LSU valid: at most one of ALU/MUL is granted, driving port A.
REQ-020 When LSU valid: the RR-preferred requester is granted if it is valid and its effective address differs from the LSU's; otherwise the other requester is granted under the same conditions.
REQ-021 When LSU idle: ALU and MUL are both granted if both are valid and their effective addresses differ; ALU drives port A and MUL drives port B.
REQ-022 When LSU idle and ALU/MUL addresses are equal: only the RR-preferred requester is granted; ALU goes to port A, MUL to port B.
REQ-023 When LSU idle and only one of ALU/MUL is valid: that requester is granted on its own port (ALU: A, MUL: B).
REQ-024 RR pointer (1 bit; 0 = ALU preferred) updates only in a contention cycle, i.e. ALU and MUL both valid and exactly one granted; the pointer then moves to the loser.
REQ-025 A granted write with effective address 0 in the integer bank (x0) completes the handshake, but the port's we output stays 0 (write dropped).
REQ-026 flush_i=1: all ready outputs 0 and the RR pointer holds; we outputs already registered from the previous cycle still complete.
REQ-027 A port with no transfer in cycle N has we=0 in cycle N+1; its waddr/wdata hold their previous values.
REQ-028 Two granted writes in the same cycle never share an effective address, so the port-B override in the register file never discards a write.

Reset
REQ-029 While rst=1 (sampled on the clk edge): we_a_o=0, we_b_o=0, waddr_a_o=waddr_b_o=0, wdata_a_o=wdata_b_o=0, busy_o=0, RR pointer=0 (ALU preferred).
REQ-030 While rst=1 all ready outputs are 0; a request valid during reset is not consumed.
REQ-031 Reset asserted mid-operation discards any registered write; we outputs are 0 in the first cycle after the reset edge.

Verification
REQ-032 LSU(x5, 0xAAAA) + ALU(x6, 0x1111) + MUL(x7, 0x2222), RR=0 -> LSU and ALU ready; next cycle port B = x5/0xAAAA, port A = x6/0x1111; MUL stalls; RR becomes 1.
REQ-033 ALU(x9) + MUL(x9), LSU idle, RR=0 -> only ALU granted, RR becomes 1; MUL held -> next cycle MUL granted on port B, RR stays 1 (no contention).
REQ-034 ALU(x0, 0xDEAD) alone -> alu_ready_o=1; next cycle we_a_o=0 and busy_o=0.
REQ-035 FPU=1, ZFINX=0: MUL(f3 = 6'h23) -> next cycle waddr_b_o=6'h23; same stimulus with ZFINX=1 -> waddr_b_o=6'h03.
REQ-036 All three valid with flush_i=1 -> all ready 0, RR unchanged, we outputs 0 next cycle.
REQ-037 rst asserted the cycle after an LSU transfer -> we_b_o=0 after the reset edge; after release, LSU(x1) gives we_b_o=1 one cycle later.
